ahb_default_responder: RTL and testbench
========================================

AHB_DEFAULT_RESPONDER -- requirements
Module: ahb_default_responder

Interface
REQ-001 Parameters SHALL be:
- ADDR_WIDTH, default 32: HADDR width.
- DATA_WIDTH, default 32: HWDATA/HRDATA width.
- RESP_MODE, default 1: 1 = ERROR response, 0 = OKAY response.
- READ_PATTERN, default 0: HRDATA value in the OKAY-mode data phase.
- CNT_WIDTH, default 8: access counter width.
REQ-002 Clocking and reset: one clock, HCLK; reset HRESETn is asynchronous and active-low.
REQ-003 Ports SHALL be:
- HCLK  in  1  clock.
- HRESETn  in  1  async active-low reset.
- HSEL  in  1  slave select.
- HADDR  in  ADDR_WIDTH  address.
- HTRANS  in  2  transfer type.
- HWRITE  in  1  direction.
- HSIZE  in  3  size.
- HBURST  in  3  burst.
- HWDATA  in  DATA_WIDTH  write data.
- HREADYin  in  1  bus ready.
- err_clr  in  1  clears counter and capture, single-cycle pulse.
- HRDATA  out  DATA_WIDTH  read data.
- HRESP  out  2  response; bit1 is always 0.
- HREADYout  out  1  slave ready.
- err_count  out  CNT_WIDTH  accepted-access count.
- err_addr  out  ADDR_WIDTH  last captured address.
- err_write  out  1  last captured HWRITE.
- err_irq  out  1  high while err_count is nonzero.

Function
REQ-004 Transfer accepted when all hold at a rising HCLK edge: HSEL=1, HREADYin=1, HTRANS[1]=1 (NONSEQ or SEQ).
REQ-005 IDLE/BUSY transfers and unselected cycles SHALL get OKAY with zero wait: HREADYout=1, HRESP=00.
REQ-006 FSM states SHALL be IDLE, ERR1, ERR2; all outputs driven from registers.
REQ-007 IDLE, accepted transfer, RESP_MODE=1 -> ERR1; otherwise stay in IDLE.
REQ-008 ERR1 (first data-phase cycle) SHALL drive HREADYout=0, HRESP=01; next state is always ERR2.
REQ-009 ERR2 SHALL drive HREADYout=1, HRESP=01; accepted transfer -> ERR1, else -> IDLE.
REQ-010 Transfers presented during ERR1 are not accepted, because HREADYin is low.
REQ-011 RESP_MODE=0: every accepted transfer gets a zero-wait OKAY; HRDATA=READ_PATTERN in the data phase of reads, 0 otherwise; write data is discarded.
REQ-012 RESP_MODE=1: HRDATA SHALL be 0 at all times.
REQ-013 Each accepted transfer, in either mode, SHALL:
- capture HADDR into err_addr and HWRITE into err_write at the accepting edge;
- increment err_count, saturating at 2^CNT_WIDTH-1.
REQ-014 err_clr SHALL zero err_count, err_addr and err_write on the next edge.
REQ-015 err_clr coincident with an accepted transfer: the transfer wins; err_count=1 and the capture holds the new transfer.
REQ-016 err_irq SHALL be registered: high the cycle after err_count becomes nonzero, low the cycle after it returns to 0.
REQ-017 HSIZE, HBURST and HWDATA SHALL NOT affect the response.

Reset
REQ-018 Asserting HRESETn SHALL immediately force:
- state = IDLE, HREADYout=1, HRESP=00, HRDATA=0;
- err_count=0, err_addr=0, err_write=0, err_irq=0.
REQ-019 Reset mid-ERR1 or mid-ERR2 SHALL abort the response; the first post-reset cycle is a zero-wait OKAY.

Structure
REQ-020 Shared package ahb_default_pkg SHALL hold:
- HTRANS encodings: IDLE 00, BUSY 01, NONSEQ 10, SEQ 11;
- HRESP encodings: OKAY 00, ERROR 01;
- FSM state encodings.
REQ-021 Counter, capture and irq logic SHALL live in one sub-module, ahb_err_log; the FSM and output registers stay in the top level.

Verification
REQ-022 Reset: hold HRESETn=0 -> HREADYout=1, HRESP=00, err_count=0, err_irq=0.
REQ-023 Single NONSEQ write, HADDR=0x1000_0040, RESP_MODE=1 ->
- cycle+1: HREADYout=0, HRESP=01;
- cycle+2: HREADYout=1, HRESP=01;
- err_addr=0x1000_0040, err_write=1, err_count=1, err_irq=1 at cycle+2.
REQ-024 Back-to-back: NONSEQ read accepted in ERR2 -> ERR1 re-entered; err_count=2; HTRANS=IDLE afterwards -> HRESP=00.
REQ-025 HTRANS=NONSEQ with HREADYin=0, and HTRANS=BUSY with HSEL=1 -> HREADYout stays 1, HRESP=00, err_count unchanged.
REQ-026 CNT_WIDTH=2, 5 accepted transfers -> err_count=3; then err_clr with a coincident transfer -> err_count=1.
REQ-027 RESP_MODE=0, READ_PATTERN=0xDEADBEEF, NONSEQ read -> next cycle HRDATA=0xDEADBEEF, HREADYout=1, HRESP=00; HRESETn asserted in ERR1 -> HREADYout=1 with no clock edge.

Source files
------------

// File: rtl/ahb_default_pkg.sv
// ahb_default_pkg: shared AHB encodings and responder FSM states.
package ahb_default_pkg;
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;
    localparam logic [1:0] HRESP_OKAY    = 2'b00;
    localparam logic [1:0] HRESP_ERROR   = 2'b01;
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ERR1 = 2'd1,
        ST_ERR2 = 2'd2
    } state_e;
endpackage

// File: rtl/ahb_err_log.sv
// ahb_err_log: saturating access counter, address/direction capture and irq.
module ahb_err_log #(
    parameter int ADDR_WIDTH = 32,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  accept,
    input  logic [ADDR_WIDTH-1:0] haddr,
    input  logic                  hwrite,
    input  logic                  err_clr,
    output logic [CNT_WIDTH-1:0]  err_count,
    output logic [ADDR_WIDTH-1:0] err_addr,
    output logic                  err_write,
    output logic                  err_irq
);
    logic [CNT_WIDTH-1:0]  count_q, count_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  write_q, write_d, irq_q, irq_d;
    // A coincident transfer overrides the clear: count restarts at one.
    always_comb begin
        count_d = accept ? (err_clr ? CNT_WIDTH'(1) : (&count_q ? count_q : count_q + 1'b1))
                         : (err_clr ? '0 : count_q);
        addr_d  = accept ? haddr : (err_clr ? '0 : addr_q);
        write_d = accept ? hwrite : (err_clr ? 1'b0 : write_q);
        irq_d   = count_q != '0;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            addr_q  <= '0;
            write_q <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            addr_q  <= addr_d;
            write_q <= write_d;
            irq_q   <= irq_d;
        end
    end
    assign err_count = count_q;
    assign err_addr  = addr_q;
    assign err_write = write_q;
    assign err_irq   = irq_q;
endmodule

// File: rtl/ahb_default_responder.sv
// ahb_default_responder: AHB default slave giving two-cycle ERROR or zero-wait OKAY,
// with a log of accepted accesses.
module ahb_default_responder
    import ahb_default_pkg::*;
#(
    parameter int                    ADDR_WIDTH   = 32,
    parameter int                    DATA_WIDTH   = 32,
    parameter int                    RESP_MODE    = 1,
    parameter logic [DATA_WIDTH-1:0] READ_PATTERN = '0,
    parameter int                    CNT_WIDTH    = 8
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  HSEL,
    input  logic [ADDR_WIDTH-1:0] HADDR,
    input  logic [1:0]            HTRANS,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [2:0]            HBURST,
    input  logic [DATA_WIDTH-1:0] HWDATA,
    input  logic                  HREADYin,
    input  logic                  err_clr,
    output logic [DATA_WIDTH-1:0] HRDATA,
    output logic [1:0]            HRESP,
    output logic                  HREADYout,
    output logic [CNT_WIDTH-1:0]  err_count,
    output logic [ADDR_WIDTH-1:0] err_addr,
    output logic                  err_write,
    output logic                  err_irq
);
    state_e                state_q, state_d;
    logic                  hready_q, hready_d;
    logic [1:0]            hresp_q, hresp_d;
    logic [DATA_WIDTH-1:0] hrdata_q, hrdata_d;
    logic                  accept;
    logic                  unused_ok;
    assign accept    = HSEL & HREADYin & HTRANS[1];
    assign unused_ok = ^{HSIZE, HBURST, HWDATA, HTRANS[0]};
    // Outputs are decoded from the next state so they come straight from flops.
    always_comb begin
        state_d  = (state_q == ST_ERR1) ? ST_ERR2 : ((accept && RESP_MODE != 0) ? ST_ERR1 : ST_IDLE);
        hready_d = state_d != ST_ERR1;
        hresp_d  = (state_d == ST_IDLE) ? HRESP_OKAY : HRESP_ERROR;
        hrdata_d = (RESP_MODE == 0 && accept && !HWRITE) ? READ_PATTERN : '0;
    end
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q  <= ST_IDLE;
            hready_q <= 1'b1;
            hresp_q  <= HRESP_OKAY;
            hrdata_q <= '0;
        end else begin
            state_q  <= state_d;
            hready_q <= hready_d;
            hresp_q  <= hresp_d;
            hrdata_q <= hrdata_d;
        end
    end
    assign HREADYout = hready_q;
    assign HRESP     = hresp_q;
    assign HRDATA    = hrdata_q;
    ahb_err_log #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .CNT_WIDTH  (CNT_WIDTH)
    ) u_log (
        .clk       (HCLK),
        .rst_n     (HRESETn),
        .accept    (accept),
        .haddr     (HADDR),
        .hwrite    (HWRITE),
        .err_clr   (err_clr),
        .err_count (err_count),
        .err_addr  (err_addr),
        .err_write (err_write),
        .err_irq   (err_irq)
    );
endmodule

// File: tb/tb_ahb_default_responder.sv
// tb_ahb_default_responder: three responder variants (ERROR, ERROR with 2-bit counter,
// OKAY with read pattern) driven by shared stimulus and checked against a response model.
module tb_ahb_default_responder;
    localparam logic [31:0] PAT = 32'hDEADBEEF;
    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        HSEL, HWRITE, err_clr;
    logic [31:0] HADDR, HWDATA;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE, HBURST;
    logic        hrin[3], hrdy[3], ewr[3], eirq[3];
    logic [1:0]  hresp[3];
    logic [31:0] hrdata[3], eaddr[3];
    logic [7:0]  cnt0, cnt2;
    logic [1:0]  cnt1;
    int mode[3] = '{1, 1, 0};
    int cmax[3] = '{255, 3, 255};
    int left[3], cnt[3];
    bit irq_m[3], wr_m[3];
    logic [31:0] addr_m[3], rd_m[3];
    int n_chk = 0, n_fail = 0;
    always #5 HCLK = ~HCLK;
    ahb_default_responder #(.RESP_MODE(1), .CNT_WIDTH(8)) dut_e (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
        .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HWDATA(HWDATA), .HREADYin(hrin[0]),
        .err_clr(err_clr), .HRDATA(hrdata[0]), .HRESP(hresp[0]), .HREADYout(hrdy[0]),
        .err_count(cnt0), .err_addr(eaddr[0]), .err_write(ewr[0]), .err_irq(eirq[0]));
    ahb_default_responder #(.RESP_MODE(1), .CNT_WIDTH(2)) dut_s (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
        .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HWDATA(HWDATA), .HREADYin(hrin[1]),
        .err_clr(err_clr), .HRDATA(hrdata[1]), .HRESP(hresp[1]), .HREADYout(hrdy[1]),
        .err_count(cnt1), .err_addr(eaddr[1]), .err_write(ewr[1]), .err_irq(eirq[1]));
    ahb_default_responder #(.RESP_MODE(0), .READ_PATTERN(PAT), .CNT_WIDTH(8)) dut_o (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
        .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HWDATA(HWDATA), .HREADYin(hrin[2]),
        .err_clr(err_clr), .HRDATA(hrdata[2]), .HRESP(hresp[2]), .HREADYout(hrdy[2]),
        .err_count(cnt2), .err_addr(eaddr[2]), .err_write(ewr[2]), .err_irq(eirq[2]));
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    function automatic logic [31:0] cnt_of(input int i);
        return (i == 0) ? {24'b0, cnt0} : (i == 1) ? {30'b0, cnt1} : {24'b0, cnt2};
    endfunction
    // left counts remaining error data-phase cycles: 2 = wait cycle, 1 = final cycle.
    task automatic check_all();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("d%0d.hready", i), hrdy[i], left[i] != 2);
            chk($sformatf("d%0d.hresp", i), hresp[i], (left[i] > 0) ? 2'b01 : 2'b00);
            chk($sformatf("d%0d.hrdata", i), hrdata[i], rd_m[i]);
            chk($sformatf("d%0d.count", i), cnt_of(i), cnt[i]);
            chk($sformatf("d%0d.addr", i), eaddr[i], addr_m[i]);
            chk($sformatf("d%0d.write", i), ewr[i], wr_m[i]);
            chk($sformatf("d%0d.irq", i), eirq[i], irq_m[i]);
        end
    endtask
    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            left[i] = 0; cnt[i] = 0; irq_m[i] = 0; wr_m[i] = 0; addr_m[i] = '0; rd_m[i] = '0;
        end
    endtask
    task automatic step(input bit sel, input logic [1:0] tr, input bit wr, input logic [31:0] a,
                        input bit en, input bit clr);
        bit acc;
        HSEL = sel; HTRANS = tr; HWRITE = wr; HADDR = a; err_clr = clr;
        HSIZE = 3'($urandom); HBURST = 3'($urandom); HWDATA = $urandom;
        for (int i = 0; i < 3; i++) hrin[i] = en && left[i] != 2;
        @(posedge HCLK);
        for (int i = 0; i < 3; i++) begin
            acc = sel && hrin[i] && tr[1];
            irq_m[i] = cnt[i] != 0;
            if (acc) begin
                cnt[i] = clr ? 1 : (cnt[i] < cmax[i] ? cnt[i] + 1 : cnt[i]);
                addr_m[i] = a; wr_m[i] = wr;
            end else if (clr) begin
                cnt[i] = 0; addr_m[i] = '0; wr_m[i] = 0;
            end
            rd_m[i] = (mode[i] == 0 && acc && !wr) ? PAT : 32'h0;
            left[i] = (acc && mode[i] == 1) ? 2 : (left[i] > 0 ? left[i] - 1 : 0);
        end
        @(negedge HCLK);
        check_all();
    endtask
    // Reset is applied between clock edges and checked before any edge arrives.
    task automatic do_reset();
        #2 HRESETn = 1'b0;
        #1 model_reset();
        chk("rst.hready0", hrdy[0], 1'b1);
        check_all();
        @(posedge HCLK);
        @(negedge HCLK);
        HRESETn = 1'b1;
    endtask
    initial begin
        HRESETn = 1'b0; HSEL = 0; HTRANS = 2'b00; HWRITE = 0; HADDR = '0; err_clr = 0;
        HSIZE = '0; HBURST = '0; HWDATA = '0;
        for (int i = 0; i < 3; i++) hrin[i] = 1'b1;
        model_reset();
        @(negedge HCLK);
        do_reset();
        step(1, 2'b10, 1, 32'h1000_0040, 1, 0);
        chk("wr.wait_rdy", hrdy[0], 1'b0);
        chk("wr.wait_resp", hresp[0], 2'b01);
        step(0, 2'b00, 0, 32'h0, 1, 0);
        chk("wr.final_rdy", hrdy[0], 1'b1);
        chk("wr.addr", eaddr[0], 32'h1000_0040);
        chk("wr.write", ewr[0], 1'b1);
        chk("wr.count", cnt0, 8'd1);
        chk("wr.irq", eirq[0], 1'b1);
        step(0, 2'b00, 0, 32'h0, 1, 0);
        step(1, 2'b10, 1, 32'h1000_0040, 1, 0);
        step(1, 2'b10, 0, 32'h0000_0044, 1, 0);
        step(1, 2'b10, 0, 32'h0000_0048, 1, 0);
        chk("b2b.rdy", hrdy[0], 1'b0);
        chk("b2b.count", cnt0, 8'd3);
        step(1, 2'b00, 0, 32'h0, 1, 0);
        step(1, 2'b00, 0, 32'h0, 1, 0);
        chk("b2b.idle_resp", hresp[0], 2'b00);
        step(1, 2'b10, 0, 32'h50, 0, 0);
        step(1, 2'b01, 0, 32'h54, 1, 0);
        chk("busy.count", cnt0, 8'd3);
        chk("busy.resp", hresp[0], 2'b00);
        do_reset();
        for (int k = 0; k < 12; k++) step(1, 2'b11, k[0], 32'h100 + k, 1, 0);
        chk("sat.count", cnt1, 2'd3);
        step(1, 2'b10, 1, 32'h200, 1, 1);
        chk("clr.count", cnt1, 2'd1);
        chk("clr.addr", eaddr[1], 32'h200);
        step(0, 2'b00, 0, 32'h0, 1, 1);
        step(0, 2'b00, 0, 32'h0, 1, 0);
        step(0, 2'b00, 0, 32'h0, 1, 0);
        chk("clr.zero", cnt1, 2'd0);
        step(1, 2'b10, 0, 32'h300, 1, 0);
        chk("okay.rdata", hrdata[2], PAT);
        chk("okay.rdy", hrdy[2], 1'b1);
        step(0, 2'b00, 0, 32'h0, 1, 0);
        step(0, 2'b00, 0, 32'h0, 1, 0);
        step(1, 2'b10, 1, 32'h400, 1, 0);
        do_reset();
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(0, 199) == 0) do_reset();
            step($urandom_range(0, 3) != 0, 2'($urandom), 1'($urandom), $urandom,
                 $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
